// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC generator: registers the next fetch PC, computes E-stage
// branch/jump/JR redirect targets and holds a redirect that lands during a stall.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        stallF,
  input  logic        validE,
  input  logic        branchE,
  input  logic        jumpE,
  input  logic        jrE,
  input  logic [31:0] pcE,
  input  logic [15:0] immE,
  input  logic [25:0] jumpIdxE,
  input  logic [31:0] rsDataE,
  output logic [31:0] pcF,
  output logic [31:0] pcPlus4F,
  output logic        redirect,
  output logic        killF,
  output logic        pendValid
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pcF;
  logic [31:0] r_pendTarget;

  logic [31:0] w_pcE4;
  logic [31:0] w_brOff;
  logic [31:0] w_brTarget;
  logic [31:0] w_jTarget;
  logic [31:0] w_target;
  logic        w_req;
  logic        w_accept;
  logic        w_release;

  assign w_pcE4     = pcE + 32'd4;
  assign w_brOff    = {{14{immE[15]}}, immE, 2'b00};
  assign w_brTarget = w_pcE4 + w_brOff;
  assign w_jTarget  = {w_pcE4[31:28], jumpIdxE, 2'b00};
  assign w_req      = validE & (branchE | jumpE | jrE);

  // JR wins over J, which wins over a taken branch.
  always_comb begin
    w_target = w_brTarget;
    if (jrE)        w_target = rsDataE;
    else if (jumpE) w_target = w_jTarget;
  end

  // A redirect is only accepted in RUN; while pending, the first one wins.
  assign w_accept  = ~Reset & (r_state == RUN) & w_req;
  assign w_release = ~Reset & (r_state == PEND) & ~stallF;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= RUN;
      r_pcF        <= RESET_VEC;
      r_pendTarget <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_req) begin
            if (!stallF) begin
              r_pcF <= w_target;
            end else begin
              r_pendTarget <= w_target;
              r_state      <= PEND;
            end
          end else if (!stallF) begin
            r_pcF <= r_pcF + 32'd4;
          end
        end
        PEND: begin
          if (!stallF) begin
            r_pcF   <= r_pendTarget;
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign pcF       = r_pcF;
  assign pcPlus4F  = r_pcF + 32'd4;
  assign redirect  = w_accept;
  assign pendValid = ~Reset & (r_state == PEND);
  assign killF     = ~DELAY_SLOT & (w_accept | w_release);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: a delay-slot instance at RESET_VEC=0 and a squashing
// instance at RESET_VEC=32'h400 share stimulus and are checked against a behavioural model.
module tb_pc_redirect_unit;

  logic        Clock = 1'b0;
  logic        Reset, stallF, validE, branchE, jumpE, jrE;
  logic [31:0] pcE, rsDataE;
  logic [15:0] immE;
  logic [25:0] jumpIdxE;

  logic [31:0] pcF [2];
  logic [31:0] pcPlus4F [2];
  logic        redirect [2];
  logic        killF [2];
  logic        pendValid [2];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // model state per instance
  logic [31:0] m_pc [2];
  logic [31:0] m_tgt [2];
  bit          m_pend [2];
  logic [31:0] rv [2];

  always #5 Clock = ~Clock;

  pc_redirect_unit dut0 (
    .Clock(Clock), .Reset(Reset), .stallF(stallF), .validE(validE),
    .branchE(branchE), .jumpE(jumpE), .jrE(jrE), .pcE(pcE), .immE(immE),
    .jumpIdxE(jumpIdxE), .rsDataE(rsDataE), .pcF(pcF[0]), .pcPlus4F(pcPlus4F[0]),
    .redirect(redirect[0]), .killF(killF[0]), .pendValid(pendValid[0])
  );

  pc_redirect_unit #(.RESET_VEC(32'h0000_0400), .DELAY_SLOT(1'b0)) dut1 (
    .Clock(Clock), .Reset(Reset), .stallF(stallF), .validE(validE),
    .branchE(branchE), .jumpE(jumpE), .jrE(jrE), .pcE(pcE), .immE(immE),
    .jumpIdxE(jumpIdxE), .rsDataE(rsDataE), .pcF(pcF[1]), .pcPlus4F(pcPlus4F[1]),
    .redirect(redirect[1]), .killF(killF[1]), .pendValid(pendValid[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_target();
    logic [31:0] pe4;
    int          off;
    pe4 = pcE + 32'd4;
    off = int'($signed(immE)) * 4;
    if (jrE)        return rsDataE;
    else if (jumpE) return (pe4 & 32'hF000_0000) | (32'(jumpIdxE) * 32'd4);
    else            return pe4 + 32'(off);
  endfunction

  function automatic bit m_req();
    return validE & (branchE | jumpE | jrE);
  endfunction

  task automatic set_in(input bit v, input bit b, input bit j, input bit r,
                        input logic [31:0] pe, input logic [15:0] im,
                        input logic [25:0] idx, input logic [31:0] rs, input bit st);
    validE = v; branchE = b; jumpE = j; jrE = r;
    pcE = pe; immE = im; jumpIdxE = idx; rsDataE = rs; stallF = st;
  endtask

  task automatic check_all();
    bit er, ek;
    for (int k = 0; k < 2; k++) begin
      er = !Reset && !m_pend[k] && m_req();
      ek = (k == 1) && !Reset && (er || (m_pend[k] && !stallF));
      chk($sformatf("pcF%0d", k), pcF[k], m_pc[k]);
      chk($sformatf("pcPlus4F%0d", k), pcPlus4F[k], m_pc[k] + 32'd4);
      chk($sformatf("redirect%0d", k), 32'(redirect[k]), 32'(er));
      chk($sformatf("killF%0d", k), 32'(killF[k]), 32'(ek));
      chk($sformatf("pendValid%0d", k), 32'(pendValid[k]), 32'(!Reset && m_pend[k]));
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    t = m_target();
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        m_pc[k] = rv[k]; m_pend[k] = 0; m_tgt[k] = '0;
      end else if (m_pend[k]) begin
        if (!stallF) begin m_pc[k] = m_tgt[k]; m_pend[k] = 0; end
      end else if (m_req()) begin
        if (!stallF) m_pc[k] = t;
        else begin m_tgt[k] = t; m_pend[k] = 1; end
      end else if (!stallF) begin
        m_pc[k] = m_pc[k] + 32'd4;
      end
    end
  endtask

  // inputs are set just after a falling edge; check, then advance one cycle
  task automatic cyc(input bit do_chk);
    #1;
    if (do_chk) check_all();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
  endtask

  task automatic idle(input bit st);
    set_in(0, 0, 0, 0, '0, '0, '0, '0, st);
  endtask

  initial begin
    rv[0] = 32'h0; rv[1] = 32'h400;
    m_pc[0] = '0; m_pc[1] = '0; m_pend[0] = 0; m_pend[1] = 0;
    m_tgt[0] = '0; m_tgt[1] = '0;
    Reset = 1; idle(0);
    @(negedge Clock);
    cyc(0);
    cyc(1);                                  // outputs gated while Reset high
    Reset = 0;

    // 1: sequential fetch from reset vector
    for (int i = 0; i < 4; i++) cyc(1);
    chk("seq_pc0", pcF[0], 32'h10);
    chk("seq_pc1", pcF[1], 32'h410);

    // 2: backward and forward branch
    set_in(1, 1, 0, 0, 32'h100, 16'hFFFE, '0, '0, 0); cyc(1);
    chk("br_back", pcF[0], 32'hFC);
    set_in(1, 1, 0, 0, 32'h100, 16'h0003, '0, '0, 0); cyc(1);
    chk("br_fwd", pcF[0], 32'h110);

    // 3: jump keeps pcE4 upper nibble; JR beats branch
    set_in(1, 0, 1, 0, 32'hF000_0010, '0, 26'h000_0040, '0, 0); cyc(1);
    chk("jump", pcF[0], 32'hF000_0100);
    set_in(1, 1, 0, 1, 32'h100, 16'h0003, '0, 32'h2000, 0); cyc(1);
    chk("jr_pri", pcF[0], 32'h2000);

    // 4: redirect during stall is pended, second request ignored
    set_in(1, 1, 0, 0, 32'h1FC, 16'h0000, '0, '0, 1); cyc(1);
    set_in(1, 0, 0, 1, '0, '0, '0, 32'h300, 1); cyc(1);
    idle(1); cyc(1); cyc(1);
    chk("pend_hold", pcF[0], 32'h2000);
    chk("pend_flag", 32'(pendValid[0]), 32'd1);
    idle(0); cyc(1);                         // release cycle
    chk("pend_apply", pcF[0], 32'h200);
    chk("pend_clr", 32'(pendValid[0]), 32'd0);
    cyc(1);

    // 6: reset mid-PEND, then masked request
    set_in(1, 1, 0, 0, 32'h500, 16'h0010, '0, '0, 1); cyc(1);
    idle(1); Reset = 1; cyc(1);
    Reset = 0; idle(0); cyc(1);
    chk("rst_pend_pc", pcF[1], 32'h404);
    set_in(0, 1, 0, 0, 32'h500, 16'h0010, '0, '0, 0); cyc(1);
    chk("masked", pcF[1], 32'h408);

    // randomized traffic, including wrap-around targets and occasional reset
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0), $urandom, 16'($urandom), 26'($urandom),
             (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom),
             ($urandom_range(0, 9) < 3));
      Reset = ($urandom_range(0, 49) == 0);
      cyc(1);
    end
    Reset = 0; idle(0); cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
